keypad_bcd_arbiter: RTL and testbench
=====================================

KEYPAD_BCD_ARBITER -- requirements
Module: keypad_bcd_arbiter

Interface
REQ-001 Parameter: ROUND_ROBIN, default 1, 1 = round-robin arbitration and 0 = fixed priority with the lowest index winning; SHALL be the only parameter.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: key_in  input  10  decimal key lines; bit k is digit k, level-sensitive, synchronous to clk.
REQ-005 Port: out_ready  input  1  consumer accepts out_bcd this cycle.
REQ-006 Port: out_valid  output  1  out_bcd holds a granted digit.
REQ-007 Port: out_bcd  output  4  BCD code of the granted digit, 0..9.
REQ-008 Port: pending  output  10  registered pending-event vector, bit k means digit k is awaiting a grant.
REQ-009 Port: overrun  output  1  one-cycle pulse when a key event is lost.

Function
REQ-010 The block SHALL register key_in into key_q every cycle and define a press as key_in[k] & ~key_q[k].
REQ-011 A press on bit k SHALL set pending[k] at the same clock edge.
REQ-012 Arbitration SHALL use the registered pending only; a press is eligible from the cycle after it sets pending.
REQ-013 The output FSM SHALL have two states: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-014 IDLE -> HOLD when pending != 0: load out_bcd with the winner's code and clear the winner's pending bit at the same edge.
REQ-015 In HOLD with out_ready=1 and pending != 0, the block SHALL load the next winner back-to-back and stay in HOLD, giving one digit per cycle.
REQ-016 HOLD -> IDLE when out_ready=1 and pending == 0.
REQ-017 In HOLD with out_ready=0, out_bcd and out_valid SHALL stay stable and no pending bit SHALL be cleared.
REQ-018 Round-robin: search indices ptr, ptr+1, ..., 9, 0, ..., ptr-1; the first set bit wins; after a grant, ptr = winner+1, wrapping 9 -> 0.
REQ-019 Fixed priority: the lowest set index wins; ptr is unused.
REQ-020 If a press on bit k and a grant that clears bit k fall on the same edge, pending[k] SHALL end set (the new press survives).
REQ-021 If a press on bit k arrives while pending[k]=1 and bit k is not being granted that edge, overrun SHALL be 1 for the following cycle only; pending[k] stays 1.
REQ-022 out_bcd SHALL be 0 whenever out_valid=0.
REQ-023 Latency: key_in rise sampled at edge t gives out_valid=1 at edge t+1 at the earliest.
REQ-024 out_bcd SHALL never hold a value above 9.

Reset
REQ-025 While rst=1: key_q=0, pending=0, ptr=0, FSM=IDLE, out_valid=0, out_bcd=0, overrun=0.
REQ-026 A key held high through reset release SHALL count as a press on the first edge after release.
REQ-027 Reset asserted mid-HOLD SHALL drop the held digit and all pending events immediately; nothing is replayed.

Structure
REQ-028 Package kp_pkg SHALL hold NUM_KEYS=10, BCD_W=4 and the FSM state enum {IDLE, HOLD}.
REQ-029 The one-hot-to-BCD conversion of the winner SHALL be a separate combinational sub-module, onehot10_to_bcd; the arbiter's rotate and mask logic stays in the top.

Verification
REQ-030 Single press: key_in=10'h008 for 3 cycles, out_ready=1 -> out_valid=1 for one cycle with out_bcd=3; pending returns to 0; overrun=0.
REQ-031 Round-robin fairness: pulse keys 2, 5 and 9 on the same edge, ptr=0, out_ready=1 -> out_bcd sequence 2, 5, 9 on consecutive cycles; then a new press of 0 -> out_bcd=0.
REQ-032 Backpressure: press 7 with out_ready=0 for 5 cycles -> out_bcd=7 held stable throughout; press 1 during the hold -> pending=10'h002; release out_ready -> 7 accepted, then 1.
REQ-033 Overrun: press 4, release, press 4 again while out_ready=0 holds another digit -> overrun pulses once; pending[4]=1.
REQ-034 Fixed priority (ROUND_ROBIN=0): press 8 and 3 together -> 3 first, then 8.
REQ-035 Reset mid-operation: rst=1 during HOLD with pending=10'h3FF -> all outputs 0 asynchronously; after release with key_in=10'h200 held -> out_bcd=9 two edges later.

Source files
------------

// File: rtl/kp_pkg.sv
// Shared constants and FSM state type for the keypad BCD arbiter.
package kp_pkg;

    localparam int NUM_KEYS = 10;
    localparam int BCD_W    = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Round-robin pointer advance: one past the winner, wrapping 9 -> 0.
    function automatic logic [BCD_W-1:0] next_ptr(input logic [BCD_W-1:0] idx);
        return (idx == BCD_W'(NUM_KEYS - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/onehot10_to_bcd.sv
// Combinational one-hot (10 lines) to BCD encoder; all-zero input encodes to 0.
module onehot10_to_bcd
    import kp_pkg::*;
(
    input  logic [NUM_KEYS-1:0] onehot,
    output logic [BCD_W-1:0]    bcd
);

    always_comb begin
        bcd = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (onehot[k]) begin
                bcd = bcd | BCD_W'(k);
            end
        end
    end

endmodule

// File: rtl/keypad_bcd_arbiter.sv
// Captures rising edges on ten key lines as pending events and hands them out
// one BCD digit at a time over a valid/ready port, round-robin or fixed priority.
module keypad_bcd_arbiter
    import kp_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [BCD_W-1:0]    out_bcd,
    output logic [NUM_KEYS-1:0] pending,
    output logic                overrun
);

    logic [NUM_KEYS-1:0] key_q;
    logic [NUM_KEYS-1:0] pending_q, pending_d;
    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] cand_oh;
    logic [NUM_KEYS-1:0] grant_oh;
    logic [BCD_W-1:0]    ptr_q, ptr_d;
    logic [BCD_W-1:0]    start;
    logic [BCD_W-1:0]    win_bcd;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [BCD_W:0]      sum;
    logic                found;
    logic                overrun_q, overrun_d;
    state_e              state_q, state_d;

    assign press = key_in & ~key_q;
    assign start = (ROUND_ROBIN != 0) ? ptr_q : '0;

    // Search pending from start upward with wrap; first set bit wins.
    always_comb begin
        cand_oh = '0;
        found   = 1'b0;
        sum     = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            sum = {1'b0, start} + (BCD_W + 1)'(i);
            if (sum >= (BCD_W + 1)'(NUM_KEYS)) begin
                sum = sum - (BCD_W + 1)'(NUM_KEYS);
            end
            if (!found && pending_q[sum[BCD_W-1:0]]) begin
                cand_oh[sum[BCD_W-1:0]] = 1'b1;
                found                   = 1'b1;
            end
        end
    end

    onehot10_to_bcd u_enc (
        .onehot (cand_oh),
        .bcd    (win_bcd)
    );

    always_comb begin
        state_d  = state_q;
        bcd_d    = bcd_q;
        ptr_d    = ptr_q;
        grant_oh = '0;
        unique case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    grant_oh = cand_oh;
                    bcd_d    = win_bcd;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (|pending_q) begin
                        grant_oh = cand_oh;
                        bcd_d    = win_bcd;
                    end else begin
                        bcd_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                bcd_d   = '0;
            end
        endcase
        if ((ROUND_ROBIN != 0) && (|grant_oh)) begin
            ptr_d = next_ptr(win_bcd);
        end
        // A fresh press on the bit being granted re-arms it instead of being lost.
        pending_d = (pending_q & ~grant_oh) | press;
        overrun_d = |(press & pending_q & ~grant_oh);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q     <= '0;
            pending_q <= '0;
            ptr_q     <= '0;
            bcd_q     <= '0;
            overrun_q <= 1'b0;
            state_q   <= IDLE;
        end else begin
            key_q     <= key_in;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            bcd_q     <= bcd_d;
            overrun_q <= overrun_d;
            state_q   <= state_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_bcd   = bcd_q;
    assign pending   = pending_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_bcd_arbiter.sv
// Scoreboard bench: directed key presses push expected digits, monitors pop on handshakes.
module tb_keypad_bcd_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] rr_key, fp_key;
    logic       rr_ready, fp_ready;
    logic       rr_valid, fp_valid;
    logic [3:0] rr_bcd, fp_bcd;
    logic [9:0] rr_pending, fp_pending;
    logic       rr_overrun, fp_overrun;

    int errors = 0;
    int checks = 0;
    int ov_rr  = 0;
    int ov_fp  = 0;
    int q_rr[$];
    int q_fp[$];
    int exp_rr, exp_fp;
    int base;

    always #5 clk = ~clk;

    keypad_bcd_arbiter #(.ROUND_ROBIN(1)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .key_in    (rr_key),
        .out_ready (rr_ready),
        .out_valid (rr_valid),
        .out_bcd   (rr_bcd),
        .pending   (rr_pending),
        .overrun   (rr_overrun)
    );

    keypad_bcd_arbiter #(.ROUND_ROBIN(0)) u_fp (
        .clk       (clk),
        .rst       (rst),
        .key_in    (fp_key),
        .out_ready (fp_ready),
        .out_valid (fp_valid),
        .out_bcd   (fp_bcd),
        .pending   (fp_pending),
        .overrun   (fp_overrun)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitors: compare every accepted digit against the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (rr_valid && rr_ready) begin
                if (q_rr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rr_unexpected_digit: got %0d expected none", rr_bcd);
                end else begin
                    exp_rr = q_rr.pop_front();
                    check("rr_digit", int'(rr_bcd), exp_rr);
                end
            end
            if (!rr_valid) check("rr_idle_bcd", int'(rr_bcd), 0);
            if (rr_overrun) ov_rr++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (fp_valid && fp_ready) begin
                if (q_fp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fp_unexpected_digit: got %0d expected none", fp_bcd);
                end else begin
                    exp_fp = q_fp.pop_front();
                    check("fp_digit", int'(fp_bcd), exp_fp);
                end
            end
            if (!fp_valid) check("fp_idle_bcd", int'(fp_bcd), 0);
            if (fp_overrun) ov_fp++;
        end
    end

    initial begin
        rst      = 1'b1;
        rr_key   = '0;
        fp_key   = '0;
        rr_ready = 1'b1;
        fp_ready = 1'b1;
        tick(2);
        @(negedge clk);
        check("reset_valid", int'(rr_valid), 0);
        check("reset_bcd", int'(rr_bcd), 0);
        check("reset_pending", int'(rr_pending), 0);
        check("reset_overrun", int'(rr_overrun), 0);
        tick(1);
        rst = 1'b0;

        // Single press of 3 held for three cycles
        rr_key = 10'h008; q_rr.push_back(3);
        tick(3);
        rr_key = '0;
        tick(2);
        @(negedge clk);
        check("single_pending", int'(rr_pending), 0);
        check("single_valid", int'(rr_valid), 0);
        check("single_overrun", ov_rr, 0);

        // Clear ptr back to 0, then fairness 2,5,9 then 0
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        rr_key = 10'h224; q_rr.push_back(2); q_rr.push_back(5); q_rr.push_back(9);
        tick(1);
        rr_key = '0;
        @(negedge clk);
        check("rr_pending_224", int'(rr_pending), 'h224);
        tick(1); @(negedge clk);
        check("rr_seq0", int'(rr_bcd), 2);
        tick(1); @(negedge clk);
        check("rr_seq1", int'(rr_bcd), 5);
        tick(1); @(negedge clk);
        check("rr_seq2", int'(rr_bcd), 9);
        tick(2);
        rr_key = 10'h001; q_rr.push_back(0);
        tick(1);
        rr_key = '0;
        tick(4);

        // Backpressure: 7 held, 1 queued behind it
        rr_ready = 1'b0;
        rr_key = 10'h080; q_rr.push_back(7);
        tick(1);
        rr_key = '0;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", int'(rr_valid), 1);
            check("hold_bcd", int'(rr_bcd), 7);
            tick(1);
        end
        rr_key = 10'h002; q_rr.push_back(1);
        tick(1);
        rr_key = '0;
        @(negedge clk);
        check("hold_pending", int'(rr_pending), 'h002);
        check("hold_bcd_after", int'(rr_bcd), 7);
        tick(1);
        rr_ready = 1'b1;
        tick(4);

        // Overrun: 4 pressed twice while 6 is stalled
        rr_ready = 1'b0;
        base = ov_rr;
        rr_key = 10'h040; q_rr.push_back(6);
        tick(1);
        rr_key = '0;
        tick(1);
        rr_key = 10'h010; q_rr.push_back(4);
        tick(1);
        rr_key = '0;
        tick(1);
        rr_key = 10'h010;
        tick(1);
        rr_key = '0;
        tick(2);
        @(negedge clk);
        check("overrun_pulses", ov_rr - base, 1);
        check("overrun_pending", int'(rr_pending), 'h010);
        check("overrun_held", int'(rr_bcd), 6);
        tick(1);
        rr_ready = 1'b1;
        tick(4);

        // Press on a bit at the same edge it is granted survives (ptr=5 here)
        rr_ready = 1'b0;
        base = ov_rr;
        rr_key = 10'h028; q_rr.push_back(5); q_rr.push_back(3);
        tick(1);
        rr_key = '0;
        tick(2);
        rr_ready = 1'b1;
        rr_key = 10'h008; q_rr.push_back(3);
        tick(1);
        rr_key = '0;
        @(negedge clk);
        check("regrant_pending", int'(rr_pending), 'h008);
        check("regrant_bcd", int'(rr_bcd), 3);
        tick(3);
        check("regrant_no_overrun", ov_rr - base, 0);

        // Reset mid-HOLD with everything pending (ptr=4 here)
        rr_ready = 1'b0;
        rr_key = 10'h3FF;
        tick(1);
        rr_key = '0;
        tick(1);
        rr_key = 10'h010;
        tick(1);
        rr_key = '0;
        @(negedge clk);
        check("full_pending", int'(rr_pending), 'h3FF);
        check("full_valid", int'(rr_valid), 1);
        #1 rst = 1'b1;
        #1;
        check("async_valid", int'(rr_valid), 0);
        check("async_bcd", int'(rr_bcd), 0);
        check("async_pending", int'(rr_pending), 0);
        check("async_overrun", int'(rr_overrun), 0);
        rr_key = 10'h200;
        tick(1);
        rr_ready = 1'b1;
        rst = 1'b0;
        q_rr.push_back(9);
        tick(1); @(negedge clk);
        check("post_reset_edge1_valid", int'(rr_valid), 0);
        tick(1); @(negedge clk);
        check("post_reset_edge2_valid", int'(rr_valid), 1);
        check("post_reset_edge2_bcd", int'(rr_bcd), 9);
        rr_key = '0;
        tick(3);

        // Fixed priority: lowest index wins regardless of history
        fp_key = 10'h020; q_fp.push_back(5);
        tick(1);
        fp_key = '0;
        tick(4);
        fp_key = 10'h084; q_fp.push_back(2); q_fp.push_back(7);
        tick(1);
        fp_key = '0;
        tick(4);
        fp_key = 10'h108; q_fp.push_back(3); q_fp.push_back(8);
        tick(1);
        fp_key = '0;
        tick(4);

        check("rr_queue_drained", q_rr.size(), 0);
        check("fp_queue_drained", q_fp.size(), 0);
        check("fp_no_overrun", ov_fp, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
